// File: rtl/operand_loader_if.sv
// Nibble-in / word-out stream bundle between the feeder side, the operand loader and the convolutor core.
interface operand_loader_if #(
  parameter int NIB_W  = 4,
  parameter int WORD_W = 12
);
  logic [NIB_W-1:0]  in_data;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/operand_loader.sv
// Packs NIB_W-bit nibbles into WORD_W-bit operand words, with one word of holding buffer; out_valid from 2 cycles after the last nibble.
// Backpressure: in_ready depends only on registered state (asm_full) and clear, never combinationally on out_ready.
module operand_loader #(
  parameter int NIB_W  = 4,
  parameter int WORD_W = 12,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  operand_loader_if.slave  bus,
  output logic             busy,
  output logic [CNT_W-1:0] words_out
);
  localparam int NIBS = WORD_W / NIB_W;
  localparam int NC_W = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam logic [NC_W-1:0] LAST_NIB = NC_W'(NIBS - 1);

  logic [NC_W-1:0]   nib_cnt_q, nib_cnt_d;
  logic              asm_full_q, asm_full_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              hold_valid_q, hold_valid_d;
  logic [CNT_W-1:0]  words_q, words_d;

  logic in_rdy;
  logic nib_acc;
  logic pop;
  logic xfer;

  assign in_rdy  = !asm_full_q && !clear;
  assign nib_acc = bus.in_valid && in_rdy;
  assign pop     = hold_valid_q && bus.out_ready;
  // Clear wins over a pending transfer, so a completed word in asm is dropped.
  assign xfer    = asm_full_q && !clear && (!hold_valid_q || pop);

  always_comb begin
    nib_cnt_d    = nib_cnt_q;
    asm_full_d   = asm_full_q;
    asm_d        = asm_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    words_d      = words_q;

    if (nib_acc) begin
      for (int i = 0; i < NIBS; i++) begin
        if (nib_cnt_q == NC_W'(i)) begin
          asm_d[i*NIB_W +: NIB_W] = bus.in_data;
        end
      end
      if (nib_cnt_q == LAST_NIB) begin
        nib_cnt_d  = '0;
        asm_full_d = 1'b1;
      end else begin
        nib_cnt_d  = nib_cnt_q + NC_W'(1);
      end
    end

    if (clear) begin
      nib_cnt_d  = '0;
      asm_full_d = 1'b0;
    end

    if (xfer) begin
      hold_d       = asm_q;
      hold_valid_d = 1'b1;
      asm_full_d   = 1'b0;
    end else if (pop) begin
      hold_valid_d = 1'b0;
    end

    if (pop) begin
      words_d = words_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nib_cnt_q    <= '0;
      asm_full_q   <= 1'b0;
      asm_q        <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      words_q      <= '0;
    end else begin
      nib_cnt_q    <= nib_cnt_d;
      asm_full_q   <= asm_full_d;
      asm_q        <= asm_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      words_q      <= words_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = hold_valid_q;
  assign bus.out_data  = hold_q;
  assign busy          = (nib_cnt_q != '0) || asm_full_q || hold_valid_q;
  assign words_out     = words_q;
endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader: directed scenarios plus a negedge monitor holding a word-level reference model.
module tb_operand_loader;
  localparam int NIB_W  = 4;
  localparam int WORD_W = 12;
  localparam int NIBS   = WORD_W / NIB_W;
  localparam int CNT_W  = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             clear;
  logic             busy;
  logic [CNT_W-1:0] words_out;

  operand_loader_if #(.NIB_W(NIB_W), .WORD_W(WORD_W)) bus ();

  operand_loader #(.NIB_W(NIB_W), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .bus       (bus),
    .busy      (busy),
    .words_out (words_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nhs   = 0;
  bit rand_mode = 0;
  bit prev_stall = 0;
  logic [WORD_W-1:0] prev_dat;
  logic [WORD_W-1:0] last_word;
  logic [NIB_W-1:0]  part_q[$];
  logic [WORD_W-1:0] exp_q[$];
  int                hs_cyc[$];

  // Reference: accepted nibbles become words in order; words in flight = words accepted but not yet popped.
  task automatic mon_step();
    logic [WORD_W-1:0] w;
    bit exp_busy;
    if (reset) begin
      part_q.delete(); exp_q.delete(); hs_cyc.delete();
      nhs = 0; prev_stall = 0;
      return;
    end
    total++;
    if (words_out !== nhs[CNT_W-1:0]) begin
      bad++; $display("FAIL mon_words_out got=%0d want=%0d t=%0t", words_out, nhs[CNT_W-1:0], $time);
    end
    exp_busy = (part_q.size() != 0) || (exp_q.size() != 0);
    total++;
    if (busy !== exp_busy) begin
      bad++; $display("FAIL mon_busy got=%0b want=%0b t=%0t", busy, exp_busy, $time);
    end
    if (exp_q.size() == 0) begin
      total++;
      if (bus.out_valid !== 1'b0) begin
        bad++; $display("FAIL mon_empty_valid got=%0b want=0 t=%0t", bus.out_valid, $time);
      end
    end
    if (exp_q.size() >= 2 || clear) begin
      total++;
      if (bus.in_ready !== 1'b0) begin
        bad++; $display("FAIL mon_in_ready_blocked got=%0b want=0 t=%0t", bus.in_ready, $time);
      end
    end
    if (prev_stall) begin
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== prev_dat) begin
        bad++; $display("FAIL mon_stall_stable got=%0b/%03h want=1/%03h t=%0t", bus.out_valid, bus.out_data, prev_dat, $time);
      end
    end
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_dat   = bus.out_data;
    if (bus.out_valid && bus.out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL mon_spurious_word got=%03h want=none t=%0t", bus.out_data, $time);
      end else begin
        w = exp_q.pop_front();
        if (bus.out_data !== w) begin
          bad++; $display("FAIL mon_word got=%03h want=%03h t=%0t", bus.out_data, w, $time);
        end
      end
      last_word = bus.out_data;
      nhs++;
      hs_cyc.push_back(cyc);
    end
    if (clear) begin
      part_q.delete();
    end else if (bus.in_valid && bus.in_ready) begin
      part_q.push_back(bus.in_data);
      if (part_q.size() == NIBS) begin
        w = '0;
        for (int i = 0; i < NIBS; i++) w[i*NIB_W +: NIB_W] = part_q[i];
        exp_q.push_back(w);
        part_q.delete();
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) bus.out_ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic send(input logic [NIB_W-1:0] n);
    bit got = 0;
    bus.in_data  = n;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin got = 1; tick(); break; end
      tick();
    end
    if (!got) begin
      total++; bad++; $display("FAIL send_timeout got=stalled want=accepted nib=%0h", n);
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_data  = NIB_W'($urandom);
  endtask

  task automatic drain();
    bit ok = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
      tick();
    end
    tick();
    if (!ok) begin
      total++; bad++; $display("FAIL drain_timeout got=busy want=idle");
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1; clear = 1'b0; rand_mode = 0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total += 5;
    if (bus.in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got=%0b want=1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", bus.out_valid); end
    if (bus.out_data !== '0)    begin bad++; $display("FAIL reset_out_data got=%03h want=0", bus.out_data); end
    if (busy !== 1'b0)          begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    if (words_out !== '0)       begin bad++; $display("FAIL reset_words got=%0d want=0", words_out); end
  endtask

  task automatic test_basic();
    apply_reset();
    bus.out_ready = 1'b1;
    send(4'h5); send(4'hA); send(4'h3); idle();
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%0b want=0", bus.out_valid); end
    tick(); @(negedge clk);
    total += 4;
    if (bus.out_valid !== 1'b1)     begin bad++; $display("FAIL basic_valid got=%0b want=1", bus.out_valid); end
    if (bus.out_data !== 12'h3A5)   begin bad++; $display("FAIL basic_word got=%03h want=3a5", bus.out_data); end
    if (bus.out_data[5:0] !== 6'h25)  begin bad++; $display("FAIL basic_A got=%02h want=25", bus.out_data[5:0]); end
    if (bus.out_data[11:6] !== 6'h0E) begin bad++; $display("FAIL basic_B got=%02h want=0e", bus.out_data[11:6]); end
    tick(); @(negedge clk);
    total += 3;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_one_cycle got=%0b want=0", bus.out_valid); end
    if (words_out !== 8'd1)     begin bad++; $display("FAIL basic_words got=%0d want=1", words_out); end
    if (busy !== 1'b0)          begin bad++; $display("FAIL basic_busy got=%0b want=0", busy); end
    tick();
  endtask

  task automatic test_backpressure();
    apply_reset();
    bus.out_ready = 1'b0;
    send(4'h5); send(4'hA); send(4'h3);
    send(4'hF); send(4'hF); send(4'h0);
    total++;
    if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_full got=%0b want=0", bus.in_ready); end
    bus.in_data = 4'h1; bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total += 2;
      if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall got=%0b want=0", bus.in_ready); end
      if (bus.out_valid !== 1'b1 || bus.out_data !== 12'h3A5) begin
        bad++; $display("FAIL bp_hold got=%0b/%03h want=1/3a5", bus.out_valid, bus.out_data);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    send(4'h1); send(4'h2); send(4'h3); idle();
    drain();
    total += 2;
    if (words_out !== 8'd3)     begin bad++; $display("FAIL bp_words got=%0d want=3", words_out); end
    if (last_word !== 12'h321)  begin bad++; $display("FAIL bp_third got=%03h want=321", last_word); end
  endtask

  task automatic test_clear();
    apply_reset();
    bus.out_ready = 1'b1;
    send(4'h1); send(4'h2);
    bus.in_data = 4'h7; bus.in_valid = 1'b1; clear = 1'b1;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL clr_in_ready got=%0b want=0", bus.in_ready); end
    tick();
    clear = 1'b0;
    send(4'h4); send(4'h5); send(4'h6); idle();
    drain();
    total += 2;
    if (words_out !== 8'd1)    begin bad++; $display("FAIL clr_words got=%0d want=1", words_out); end
    if (last_word !== 12'h654) begin bad++; $display("FAIL clr_word got=%03h want=654", last_word); end
  endtask

  task automatic test_back_to_back();
    logic [WORD_W-1:0] w2;
    logic [NIB_W-1:0]  n;
    apply_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4 * NIBS; i++) send(NIB_W'($urandom));
    idle();
    drain();
    total++;
    if (words_out !== 8'd4) begin bad++; $display("FAIL stream_words got=%0d want=4", words_out); end
    for (int i = 1; i < 4; i++) begin
      total++;
      if (hs_cyc.size() != 4 || hs_cyc[i] - hs_cyc[i-1] != 4) begin
        bad++; $display("FAIL stream_spacing got=%0d want=4 idx=%0d", (hs_cyc.size() == 4) ? hs_cyc[i] - hs_cyc[i-1] : -1, i);
      end
    end
    bus.out_ready = 1'b0;
    for (int i = 0; i < NIBS; i++) send(NIB_W'($urandom));
    idle(); tick(); tick();
    w2 = '0;
    for (int i = 0; i < NIBS; i++) begin
      n = NIB_W'($urandom);
      w2[i*NIB_W +: NIB_W] = n;
      send(n);
    end
    idle();
    total++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL simul_setup got=%0b/%0b want=1/0", bus.out_valid, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    @(negedge clk); tick(); @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== w2) begin
      bad++; $display("FAIL simul_reload got=%0b/%03h want=1/%03h", bus.out_valid, bus.out_data, w2);
    end
    tick(); @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL simul_done got=%0b want=0", bus.out_valid); end
    tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < NIBS; i++) send(NIB_W'($urandom));
    idle(); drain();
    bus.out_ready = 1'b0;
    for (int i = 0; i < NIBS + 2; i++) send(NIB_W'($urandom));
    idle(); tick(); tick();
    total++;
    if (bus.out_valid !== 1'b1 || words_out !== 8'd1) begin
      bad++; $display("FAIL rstmid_setup got=%0b/%0d want=1/1", bus.out_valid, words_out);
    end
    #2 reset = 1'b1;
    #1;
    total += 5;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%0b want=0", bus.out_valid); end
    if (bus.out_data !== '0)    begin bad++; $display("FAIL rstmid_data got=%03h want=0", bus.out_data); end
    if (bus.in_ready !== 1'b1)  begin bad++; $display("FAIL rstmid_in_ready got=%0b want=1", bus.in_ready); end
    if (words_out !== '0)       begin bad++; $display("FAIL rstmid_words got=%0d want=0", words_out); end
    if (busy !== 1'b0)          begin bad++; $display("FAIL rstmid_busy got=%0b want=0", busy); end
    @(posedge clk); #1 reset = 1'b0;
    bus.out_ready = 1'b1;
    send(4'h7); send(4'h8); send(4'h9); idle();
    drain();
    total += 2;
    if (last_word !== 12'h987) begin bad++; $display("FAIL rstmid_after got=%03h want=987", last_word); end
    if (words_out !== 8'd1)    begin bad++; $display("FAIL rstmid_after_words got=%0d want=1", words_out); end
  endtask

  task automatic test_wrap();
    apply_reset();
    bus.out_ready = 1'b1;
    for (int w = 0; w < 255; w++)
      for (int i = 0; i < NIBS; i++) send(NIB_W'($urandom));
    idle(); drain();
    total++;
    if (words_out !== 8'hFF) begin bad++; $display("FAIL wrap_pre got=%0d want=255", words_out); end
    for (int i = 0; i < NIBS; i++) send(NIB_W'($urandom));
    idle(); drain();
    total += 2;
    if (words_out !== 8'h00) begin bad++; $display("FAIL wrap_post got=%0d want=0", words_out); end
    if (busy !== 1'b0)       begin bad++; $display("FAIL wrap_busy got=%0b want=0", busy); end
  endtask

  task automatic test_random();
    apply_reset();
    rand_mode = 1;
    for (int i = 0; i < 20 * NIBS; i++) begin
      idle();
      repeat ($urandom_range(0, 2)) tick();
      send(NIB_W'($urandom));
    end
    idle();
    rand_mode = 0;
    bus.out_ready = 1'b1;
    drain();
    total++;
    if (words_out !== 8'd20) begin bad++; $display("FAIL rand_words got=%0d want=20", words_out); end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    fork
      forever begin @(posedge clk); cyc++; end
      forever begin @(negedge clk); mon_step(); end
    join_none
    test_reset();
    test_basic();
    test_backpressure();
    test_clear();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
